// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 pipeline control blocks:
// the hazard FSM state, the x0 register index and the stall/flush control bundle.
package core_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_bubble;
    logic ifid_flush;
    logic freeze;
  } ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam ctrl_t CTRL_RUN = '{
    pc_we:       1'b1,
    ifid_we:     1'b1,
    idex_bubble: 1'b0,
    ifid_flush:  1'b0,
    freeze:      1'b0
  };

  function automatic logic src_matches(input logic use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32 core: load-use bubbles, data-memory
// wait freezes, taken-branch flushes, saturating perf counters and a sticky timeout.
module hazard_stall_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_use_rs1_i,
  input  logic             ID_use_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             ID_branch_taken_i,
  input  logic             MEM_req_i,
  input  logic             dmem_ready_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IDEX_Bubble_o,
  output logic             IFID_Flush_o,
  output logic             Pipe_Freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o
);

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_t          r_state;
  state_t          w_state_eff;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_wait_cnt;
  logic [TO_W-1:0] w_wait_nxt;
  logic            r_timeout;
  logic            w_mem_stall;
  logic            w_load_use;
  ctrl_t           w_ctrl;

  // While reset is asserted the controls are decoded as if already back in RUN.
  assign w_state_eff = rst_i ? RUN : r_state;

  assign w_mem_stall = (w_state_eff == MEM_WAIT) ||
                       ((w_state_eff == RUN) && MEM_req_i && !dmem_ready_i);

  assign w_load_use = EX_MemRead_i && (EX_Rd_i != REG_X0) &&
                      (src_matches(ID_use_rs1_i, ID_rs1_i, EX_Rd_i) ||
                       src_matches(ID_use_rs2_i, ID_rs2_i, EX_Rd_i));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (w_mem_stall) begin
      w_ctrl.pc_we   = 1'b0;
      w_ctrl.ifid_we = 1'b0;
      w_ctrl.freeze  = 1'b1;
    end else if (w_load_use) begin
      // A taken branch here is not flushed; it re-resolves once the load data is forwardable.
      w_ctrl.pc_we       = 1'b0;
      w_ctrl.ifid_we     = 1'b0;
      w_ctrl.idex_bubble = 1'b1;
    end else if (ID_branch_taken_i) begin
      w_ctrl.ifid_flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (MEM_req_i && !dmem_ready_i) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) w_state_nxt = RUN;
        if (r_wait_cnt != TIMEOUT_C) w_wait_nxt = r_wait_cnt + 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: reset is synchronous and takes priority over every input, even mid-wait.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if ((r_state == MEM_WAIT) && (w_wait_nxt == TIMEOUT_C)) r_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (w_mem_stall || w_load_use),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (w_ctrl.ifid_flush),
    .cnt_o (flush_cnt_o)
  );

  assign PCWrite_o     = w_ctrl.pc_we;
  assign IFID_Write_o  = w_ctrl.ifid_we;
  assign IDEX_Bubble_o = w_ctrl.idex_bubble;
  assign IFID_Flush_o  = w_ctrl.ifid_flush;
  assign Pipe_Freeze_o = w_ctrl.freeze;
  assign mem_timeout_o = r_timeout;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32 core; it is the stall/flush counterpart of the EX-stage forwarding unit.
- Detects hazards that forwarding cannot resolve: load-use, multi-cycle data-memory access, and taken branches resolved in ID.
- Drives PC / IF-ID write enables, the ID-EX bubble and the IF-ID flush.
- Keeps saturating stall and flush performance counters, plus a sticky memory-timeout flag.

Parameters:
- CNT_W, 32, width of the performance counters.
- TIMEOUT, 64, maximum number of MEM_WAIT cycles before mem_timeout_o is raised.
- TO_W, 7, width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset.
- ID_rs1_i  in  5  rs1 of the instruction in ID.
- ID_rs2_i  in  5  rs2 of the instruction in ID.
- ID_use_rs1_i  in  1  the ID instruction reads rs1.
- ID_use_rs2_i  in  1  the ID instruction reads rs2.
- EX_MemRead_i  in  1  the instruction in EX is a load.
- EX_Rd_i  in  5  rd of the instruction in EX.
- ID_branch_taken_i  in  1  a branch or jump in ID resolved as taken.
- MEM_req_i  in  1  the MEM stage issues a data-memory access this cycle.
- dmem_ready_i  in  1  data memory has completed the access.
- PCWrite_o  out  1  PC update enable.
- IFID_Write_o  out  1  IF/ID register write enable.
- IDEX_Bubble_o  out  1  force a NOP into ID/EX.
- IFID_Flush_o  out  1  clear IF/ID to a NOP.
- Pipe_Freeze_o  out  1  hold EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  count of stall cycles.
- flush_cnt_o  out  CNT_W  count of flushes.
- mem_timeout_o  out  1  sticky memory-timeout error.

Interface rule (already decided): one clock, clk_i; rst_i is synchronous and active-high.

Behaviour:
- FSM states: RUN, MEM_WAIT.
  - Reset: state=RUN, wait_cnt=0, stall_cnt_o=0, flush_cnt_o=0, mem_timeout_o=0.
  - Reset has priority over all inputs, including mid-wait: the state returns to RUN the next edge.
- Control outputs are combinational from state and inputs (zero latency).
  - In RUN with no hazard: PCWrite_o=1, IFID_Write_o=1, IDEX_Bubble_o=0, IFID_Flush_o=0, Pipe_Freeze_o=0.
  - During reset the outputs follow the same equations with state=RUN.
- mem_stall = (state==MEM_WAIT) || (state==RUN && MEM_req_i && !dmem_ready_i).
  - A same-cycle ready costs no stall.
- load_use = EX_MemRead_i && EX_Rd_i!=0 && ((ID_use_rs1_i && EX_Rd_i==ID_rs1_i) || (ID_use_rs2_i && EX_Rd_i==ID_rs2_i)).
- Priority 1, mem_stall:
  - PCWrite_o=0, IFID_Write_o=0, Pipe_Freeze_o=1.
  - IDEX_Bubble_o=0 (ID/EX holds), IFID_Flush_o=0.
  - load_use and branch are ignored.
- Priority 2, load_use without mem_stall:
  - PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1.
  - IFID_Flush_o=0, even if ID_branch_taken_i=1; the branch re-resolves next cycle with correct operands.
- Priority 3, ID_branch_taken_i without stall: IFID_Flush_o=1, PC loads the target.
- Transitions:
  - RUN -> MEM_WAIT when MEM_req_i && !dmem_ready_i.
  - MEM_WAIT -> RUN on the cycle dmem_ready_i=1. That cycle is still frozen; the pipeline advances on the following cycle.
  - MEM_req_i is ignored while in MEM_WAIT.
- wait_cnt:
  - Cleared on entering MEM_WAIT; increments every MEM_WAIT cycle and saturates at TIMEOUT.
  - When wait_cnt reaches TIMEOUT, mem_timeout_o is set and stays 1 until reset. The FSM keeps waiting.
- stall_cnt_o: +1 every cycle with mem_stall or load_use. flush_cnt_o: +1 every cycle with IFID_Flush_o=1.
  - Both saturate at all-ones and never wrap.
- x0 is never a hazard source: EX_Rd_i=0 gives no load_use.

Decomposition:
- Shared package (core_pkg):
  - FSM state typedef (RUN, MEM_WAIT).
  - REG_X0 = 5'd0 constant.
  - A control-bundle typedef {pc_we, ifid_we, idex_bubble, ifid_flush, freeze}.
- One sub-module, sat_counter (parameter W; inc, clr -> cnt), instantiated for stall_cnt_o and flush_cnt_o.

Test Plan:
1. Load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_rs1_i=5, ID_use_rs1_i=1 for 1 cycle -> PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 that cycle; stall_cnt_o=1 next cycle. Repeat with EX_Rd_i=0 -> no stall.
2. Memory wait: MEM_req_i=1, dmem_ready_i=0 for 3 cycles, then 1 -> Pipe_Freeze_o=1 for 4 cycles, state back in RUN after, stall_cnt_o=4. Same-cycle ready -> 0 stalls.
3. Branch vs load-use: ID_branch_taken_i=1 together with a load_use -> IFID_Flush_o=0, bubble=1. Branch alone next cycle -> IFID_Flush_o=1, flush_cnt_o=1.
4. Timeout: TIMEOUT=4, dmem_ready_i held 0 -> mem_timeout_o=1 after the 4th wait cycle and stays 1 after ready returns, until rst_i.
5. Reset mid-wait: rst_i=1 during MEM_WAIT with ready=0 -> next cycle state RUN, counters 0, Pipe_Freeze_o equals MEM_req_i && !dmem_ready_i.
6. Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_cnt_o stays at 15.
